// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad encoder: FSM states, key map,
// default timing constants and small decode helpers.
package keypad_pkg;

  // Defaults sized for a 100 MHz clock.
  localparam int unsigned ROW_CYC_DEF    = 1000;      // 10 us row dwell
  localparam int unsigned DEB_CYC_DEF    = 1000000;   // 10 ms debounce
  localparam int unsigned REPEAT_CYC_DEF = 50000000;  // 0.5 s auto-repeat

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    PRESSED,
    DEB_REL
  } kp_state_t;

  // Hex code per key, indexed {row, col}.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  // Index of the lowest-numbered low (pressed) column.
  function automatic logic [1:0] lowest_low_col(input logic [3:0] cols);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!cols[3-i]) idx = 2'(3 - i);
    end
    return idx;
  endfunction

  // One-hot active-low row drive pattern.
  function automatic logic [3:0] row_drive(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction

  function automatic logic [3:0] key_lookup(input logic [1:0] row,
                                            input logic [1:0] col);
    return KEY_MAP[{row, col}];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Width-parameterized two-flop synchronizer; resets to all-ones so that
// active-low inputs read as idle while in reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_encoder_4x4.sv
// 4x4 matrix keypad scanner, debouncer and hex encoder.
// Rows are driven one-hot active-low; columns are read active-low.
// Optional auto-repeat of key_valid while a key stays pressed is enabled
// by defining KEYPAD_REPEAT_EN.
module keypad_encoder_4x4
  import keypad_pkg::*;
#(
  parameter int unsigned ROW_CYC    = ROW_CYC_DEF,
  parameter int unsigned DEB_CYC    = DEB_CYC_DEF,
  parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned ROW_W = (ROW_CYC > 1) ? $clog2(ROW_CYC) : 1;
  localparam int unsigned DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_CYC - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

  // Elaboration-time parameter sanity checks.
  if (ROW_CYC < 4) begin : g_bad_row_cyc
    $error("keypad_encoder_4x4: ROW_CYC must be >= 4");
  end
  if (DEB_CYC < 2) begin : g_bad_deb_cyc
    $error("keypad_encoder_4x4: DEB_CYC must be >= 2");
  end
  if (REPEAT_CYC < 2) begin : g_bad_rep_cyc
    $error("keypad_encoder_4x4: REPEAT_CYC must be >= 2");
  end

  logic [3:0]       w_col_s;
  logic             w_col_bit;

  kp_state_t        r_state;
  logic [1:0]       r_row;
  logic [1:0]       r_col;
  logic [3:0]       r_row_n;
  logic [ROW_W-1:0] r_dwell;
  logic [DEB_W-1:0] r_deb;
  logic [3:0]       r_code;
  logic             r_valid;
  logic             r_held;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);
  logic [REP_W-1:0] r_rep;
`endif

  sync_2ff #(
    .WIDTH(4)
  ) u_col_sync (
    .i_clk  (clk),
    .i_rstn (rstn),
    .i_d    (col_n),
    .o_q    (w_col_s)
  );

  // Level of the latched column; only meaningful outside SCAN.
  assign w_col_bit = w_col_s[r_col];

  // Scan / debounce FSM with registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= SCAN;
      r_row   <= '0;
      r_col   <= '0;
      r_row_n <= 4'b1110;
      r_dwell <= '0;
      r_deb   <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep   <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        SCAN: begin
          if (r_dwell == ROW_LAST) begin
            r_dwell <= '0;
            if (w_col_s != 4'hF) begin
              // Row drive stays frozen on the current row from here on.
              r_col   <= lowest_low_col(w_col_s);
              r_deb   <= '0;
              r_state <= DEB_PRESS;
            end else begin
              r_row   <= r_row + 2'd1;
              r_row_n <= row_drive(r_row + 2'd1);
            end
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end

        DEB_PRESS: begin
          if (w_col_bit) begin
            r_row   <= r_row + 2'd1;
            r_row_n <= row_drive(r_row + 2'd1);
            r_dwell <= '0;
            r_state <= SCAN;
          end else if (r_deb == DEB_LAST) begin
            r_code  <= key_lookup(r_row, r_col);
            r_valid <= 1'b1;
            r_held  <= 1'b1;
            r_state <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
            r_rep   <= '0;
`endif
          end else begin
            r_deb <= r_deb + 1'b1;
          end
        end

        PRESSED: begin
          if (w_col_bit) begin
            r_deb   <= '0;
            r_state <= DEB_REL;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (r_rep == REP_LAST) begin
            r_rep   <= '0;
            r_valid <= 1'b1;
          end else begin
            r_rep <= r_rep + 1'b1;
          end
`endif
        end

        DEB_REL: begin
          if (!w_col_bit) begin
            r_state <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
            r_rep   <= '0;
`endif
          end else if (r_deb == DEB_LAST) begin
            r_held  <= 1'b0;
            r_row   <= r_row + 2'd1;
            r_row_n <= row_drive(r_row + 2'd1);
            r_dwell <= '0;
            r_state <= SCAN;
          end else begin
            r_deb <= r_deb + 1'b1;
          end
        end

        default: begin
          r_state <= SCAN;
        end
      endcase
    end
  end

  assign row_n     = r_row_n;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_encoder_4x4.sv
// Directed self-checking bench for keypad_encoder_4x4 with short timing
// (ROW_CYC=4, DEB_CYC=16, REPEAT_CYC=40) and a behavioural keypad matrix.
module tb_keypad_encoder_4x4;

  logic        clk;
  logic        rstn;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys;   // pressed keys, index {row, col}

  int unsigned checks;
  int unsigned failures;

  int unsigned cyc;
  int unsigned n_valid;
  int unsigned v_time [16];
  logic [3:0]  v_code [16];

  keypad_encoder_4x4 #(
    .ROW_CYC    (4),
    .DEB_CYC    (16),
    .REPEAT_CYC (40)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_n[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (keys[r*4+c]) col_n[c] = 1'b0;
        end
      end
    end
  end

  // Strobe recorder.
  always @(negedge clk) begin
    cyc++;
    if (key_valid === 1'b1) begin
      if (n_valid < 16) begin
        v_time[n_valid] = cyc;
        v_code[n_valid] = key_code;
      end
      n_valid++;
    end
  end

  // Step n falling edges, then settle just past them.
  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_held(input logic lvl, input int unsigned maxc, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < maxc; i++) begin
      if (key_held === lvl) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_row;
    rstn = 1'b0;
    keys = '0;
    tick(3);
    checks++;
    if (row_n !== 4'b1110) begin failures++; $display("FAIL reset_row_n got=%b exp=1110", row_n); end
    checks++;
    if (key_code !== 4'h0) begin failures++; $display("FAIL reset_key_code got=%h exp=0", key_code); end
    checks++;
    if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_key_valid got=%b exp=0", key_valid); end
    checks++;
    if (key_held !== 1'b0) begin failures++; $display("FAIL reset_key_held got=%b exp=0", key_held); end
    rstn = 1'b1;
    for (int unsigned k = 0; k <= 16; k++) begin
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      checks++;
      if (row_n !== exp_row) begin
        failures++;
        $display("FAIL scan_rotate k=%0d got=%b exp=%b", k, row_n, exp_row);
      end
      tick(1);
    end
  endtask

  task automatic test_single_press;
    int unsigned n0;
    bit ok;
    n0 = n_valid;
    keys[6] = 1'b1;  // row 1, col 2 -> 6
    wait_held(1'b1, 100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_accept_timeout held=%b exp=1", key_held); end
    checks++;
    if (n_valid - n0 !== 1) begin failures++; $display("FAIL single_strobes got=%0d exp=1", n_valid - n0); end
    checks++;
    if (key_code !== 4'h6) begin failures++; $display("FAIL single_code got=%h exp=6", key_code); end
    tick(20);
    checks++;
    if (row_n !== 4'b1101) begin failures++; $display("FAIL single_row_frozen got=%b exp=1101", row_n); end
    checks++;
    if (n_valid - n0 !== 1) begin failures++; $display("FAIL single_no_repeat got=%0d exp=1", n_valid - n0); end
    keys[6] = 1'b0;
    tick(5);
    checks++;
    if (key_held !== 1'b1) begin failures++; $display("FAIL single_held_during_rel got=%b exp=1", key_held); end
    wait_held(1'b0, 60, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_release_timeout held=%b exp=0", key_held); end
    checks++;
    if (row_n !== 4'b1011) begin failures++; $display("FAIL single_resume_row got=%b exp=1011", row_n); end
    tick(4);
  endtask

  task automatic test_bounce;
    int unsigned n0;
    bit ok;
    n0 = n_valid;
    for (int unsigned i = 0; i < 12; i++) begin
      keys[12] = (i % 2 == 0);  // row 3, col 0 -> 0
      tick(5);
    end
    checks++;
    if (n_valid !== n0) begin failures++; $display("FAIL bounce_no_strobe got=%0d exp=0", n_valid - n0); end
    keys[12] = 1'b1;
    wait_held(1'b1, 100, ok);
    checks++;
    if (!ok || n_valid - n0 !== 1) begin
      failures++;
      $display("FAIL bounce_accept held=%b strobes=%0d exp=1", key_held, n_valid - n0);
    end
    checks++;
    if (key_code !== 4'h0) begin failures++; $display("FAIL bounce_code got=%h exp=0", key_code); end
    keys = '0;
    wait_held(1'b0, 60, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bounce_release_timeout held=%b exp=0", key_held); end
    tick(4);
  endtask

  task automatic test_multi_key;
    int unsigned n0;
    bit ok;
    n0 = n_valid;
    keys[1] = 1'b1;  // row 0, col 1 -> 2
    keys[2] = 1'b1;  // row 0, col 2 -> 3
    wait_held(1'b1, 100, ok);
    checks++;
    if (!ok || key_code !== 4'h2) begin
      failures++;
      $display("FAIL multi_lowest_col held=%b code=%h exp=2", key_held, key_code);
    end
    keys[8] = 1'b1;  // row 2, col 0 -> 7, must be ignored
    tick(40);
    checks++;
    if (n_valid - n0 !== 1) begin failures++; $display("FAIL multi_second_key strobes=%0d exp=1", n_valid - n0); end
    checks++;
    if (key_code !== 4'h2 || key_held !== 1'b1) begin
      failures++;
      $display("FAIL multi_hold code=%h held=%b exp code=2 held=1", key_code, key_held);
    end
    keys = '0;
    wait_held(1'b0, 60, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL multi_release_timeout held=%b exp=0", key_held); end
    tick(4);
  endtask

  task automatic test_release_glitch;
    int unsigned n0;
    bit ok;
    bit dropped;
    keys[9] = 1'b1;  // row 2, col 1 -> 8
    wait_held(1'b1, 100, ok);
    checks++;
    if (!ok || key_code !== 4'h8) begin
      failures++;
      $display("FAIL glitch_accept held=%b code=%h exp=8", key_held, key_code);
    end
    n0 = n_valid;
    dropped = 1'b0;
    keys[9] = 1'b0;
    for (int unsigned i = 0; i < 30; i++) begin
      if (i == 5) keys[9] = 1'b1;
      tick(1);
      if (key_held !== 1'b1) dropped = 1'b1;
    end
    checks++;
    if (dropped) begin failures++; $display("FAIL glitch_held_drop got=0 exp=1"); end
    checks++;
    if (n_valid !== n0) begin failures++; $display("FAIL glitch_new_strobe got=%0d exp=0", n_valid - n0); end
    keys = '0;
    wait_held(1'b0, 60, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL glitch_release_timeout held=%b exp=0", key_held); end
    tick(4);
  endtask

  task automatic test_repeat;
    int unsigned n0;
    int unsigned exp_n;
    bit ok;
`ifdef KEYPAD_REPEAT_EN
    exp_n = 4;
`else
    exp_n = 1;
`endif
    n0 = n_valid;
    keys[15] = 1'b1;  // row 3, col 3 -> D
    wait_held(1'b1, 100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL repeat_accept_timeout held=%b exp=1", key_held); end
    tick(130);
    checks++;
    if (n_valid - n0 !== exp_n) begin
      failures++;
      $display("FAIL repeat_count got=%0d exp=%0d", n_valid - n0, exp_n);
    end
    for (int unsigned i = n0; i < n_valid && i < 16; i++) begin
      checks++;
      if (v_code[i] !== 4'hD) begin failures++; $display("FAIL repeat_code idx=%0d got=%h exp=D", i - n0, v_code[i]); end
      if (i > n0) begin
        checks++;
        if (v_time[i] - v_time[i-1] !== 40) begin
          failures++;
          $display("FAIL repeat_interval idx=%0d got=%0d exp=40", i - n0, v_time[i] - v_time[i-1]);
        end
      end
    end
    keys = '0;
    wait_held(1'b0, 60, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL repeat_release_timeout held=%b exp=0", key_held); end
    tick(4);
  endtask

  task automatic test_reset_abort;
    int unsigned n0;
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    keys[5] = 1'b1;  // row 1, col 1 -> 5
    n0 = n_valid;
    tick(12);
    checks++;
    if (row_n !== 4'b1101) begin failures++; $display("FAIL abort_row_frozen got=%b exp=1101", row_n); end
    tick(3);
    rstn = 1'b0;
    #1;
    checks++;
    if (row_n !== 4'b1110 || key_held !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'h0) begin
      failures++;
      $display("FAIL abort_reset_outputs row=%b held=%b valid=%b code=%h exp row=1110 held=0 valid=0 code=0",
               row_n, key_held, key_valid, key_code);
    end
    tick(20);
    keys = '0;
    checks++;
    if (n_valid !== n0) begin failures++; $display("FAIL abort_strobe got=%0d exp=0", n_valid - n0); end
    rstn = 1'b1;
    tick(4);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    n_valid  = 0;
    keys     = '0;
    rstn     = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_key();
    test_release_glitch();
    test_repeat();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/keypad_encoder_4x4.md
Name: keypad_encoder_4x4

Overview:
- Scans a 4x4 matrix keypad (Pmod KYPD on Nexys4-DDR), debounces it, and encodes the pressed key into a 4-bit hex code.
- It is the input-side counterpart of the PDU's hex-to-segment and digit-select decoders: keypress -> hex nibble, which then feeds the PDU data path.
- Rows are driven one-hot active-low. Columns are read active-low through board pull-ups.

Parameters:
- ROW_CYC, 1000, clock cycles each row is driven before its columns are sampled (10 us at 100 MHz); must be >= 4.
- DEB_CYC, 1000000, consecutive stable cycles required to accept a press or a release (10 ms at 100 MHz); must be >= 2.
- REPEAT_CYC, 50000000, auto-repeat interval in cycles; used only when KEYPAD_REPEAT_EN is defined.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- col_n  input  4  keypad columns, active-low, asynchronous to clk.
- row_n  output  4  keypad row drive, one-hot active-low.
- key_code  output  4  hex code of the last accepted key.
- key_valid  output  1  one-cycle strobe when a new key is accepted.
- key_held  output  1  high while the accepted key remains pressed.

Behaviour:
- Reset (async, rstn=0):
  - row_n=4'b1110, key_code=4'h0, key_valid=0, key_held=0.
  - FSM goes to SCAN; all counters are cleared.
  - Assertion mid-operation aborts any press in progress with no strobe.
- Synchronization: col_n passes through a 2-FF synchronizer to give col_s; only col_s is used.
- Key map, row r / column c -> code:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- FSM states: SCAN, DEB_PRESS, PRESSED, DEB_REL.
- SCAN:
  - The row index advances every ROW_CYC cycles and wraps 3 -> 0. row_n = ~(1 << row).
  - col_s is sampled only on the last cycle of each dwell.
  - If the sample != 4'hF: latch the row and the lowest-index low column, then enter DEB_PRESS. The row drive freezes.
- DEB_PRESS:
  - Counts cycles with col_s[latched col]==0.
  - If that bit goes high, return to SCAN and resume at the next row.
  - When the count reaches DEB_CYC, enter PRESSED. In the same cycle: key_code = map(row,col), key_valid=1 for exactly one cycle, key_held=1.
- PRESSED:
  - The row stays frozen.
  - col_s[latched col]==1 -> enter DEB_REL.
- DEB_REL:
  - Counts consecutive high cycles.
  - A low during the count returns to PRESSED with no new strobe.
  - When the count reaches DEB_CYC, key_held=0 and the FSM enters SCAN at the next row.
- Other keys pressed during DEB_PRESS, PRESSED or DEB_REL are ignored. If several columns in one row are low, the lowest index wins.
- key_code holds its value until the next accepted press.
- Worst-case press latency is 4*ROW_CYC + 2 + DEB_CYC cycles.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined: in PRESSED, a cycle counter runs. Every REPEAT_CYC cycles of continuous PRESSED, key_valid pulses again with the same key_code. The counter clears on entry to PRESSED. It pauses during DEB_REL and clears when PRESSED is re-entered from DEB_REL.
- Undefined: exactly one key_valid per accepted press. The counter logic is absent.

Decomposition:
- Package keypad_pkg holds:
  - the state enum (SCAN, DEB_PRESS, PRESSED, DEB_REL);
  - the 16-entry key-map constant array indexed {row,col};
  - the ROW_CYC, DEB_CYC and REPEAT_CYC default constants.
- Sub-module sync_2ff (width-parameterized 2-flop synchronizer, async active-low reset to all-ones) is used for col_n.

Test Plan (ROW_CYC=4, DEB_CYC=16, REPEAT_CYC=40):
- Reset check: hold rstn=0, then release with col_n=4'hF -> row_n=1110, key_code=0, key_valid=0; row_n rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, changing every 4 cycles.
- Single press: col_n[2] low only while row_n=1101, held 40 cycles -> exactly one key_valid, key_code=4'h6, key_held=1; after release and 16 stable cycles key_held=0 and scanning resumes at row 2.
- Bounce: toggle col_n[0] (row 3) every 5 cycles for 60 cycles, then hold low -> no key_valid during bouncing; one key_valid with key_code=4'h0 after 16 stable cycles.
- Multi-key: row 0, col_n=4'b1001 (columns 1 and 2 low) -> key_code=4'h2. While held, also press row 2 col 0 -> no second strobe.
- Release glitch: in PRESSED, pulse the column high for 5 cycles -> stays/returns to PRESSED, key_held stays 1, no new key_valid.
- KEYPAD_REPEAT_EN: hold key 'D' (row 3, col 3) 130 cycles past acceptance -> key_valid at acceptance, then at +40, +80 and +120, all with code 4'hD. With the macro undefined -> a single strobe.
